glip_stream_upscale: RTL and testbench

- Width up-converter on the logic side of the GLIP FIFO interface.
- Consumes the narrow incoming word stream (fifo_in_* of the FX3 toplevel) and packs RATIO consecutive words into one wide word for user logic.
- Supports explicit flush of a partially filled word, with a lane count, so short transfers are not stranded.
- Single clock domain; valid/ready handshake on both sides.

---
 rtl/glip_stream_upscale.sv | 156 +++++++++++++++
 tb/tb_glip_stream_upscale.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glip_stream_upscale.sv
// glip_stream_upscale: packs RATIO narrow GLIP FIFO words into one wide word (lane 0 first),
// with lane-counted flush of partial words. Define GLIP_UPSCALE_TIMEOUT_EN for idle-timeout auto flush.
module glip_stream_upscale #(
   parameter int WIDTH_IN = 16,
   parameter int RATIO    = 2,
   parameter int TIMEOUT  = 1000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [WIDTH_IN-1:0]           in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          flush,
   output logic [WIDTH_IN*RATIO-1:0]     out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(RATIO+1)-1:0]    out_lanes
);

   localparam int CNT_W   = $clog2(RATIO);
   localparam int LANES_W = $clog2(RATIO+1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [RATIO-2:0][WIDTH_IN-1:0]   acc_q, acc_d;
   logic [WIDTH_IN*RATIO-1:0]        out_data_q, out_data_d;
   logic [LANES_W-1:0]               out_lanes_q, out_lanes_d;
   logic                             out_valid_q, out_valid_d;
   logic                             flush_pending_q, flush_pending_d;

   logic                             slot_free;
   logic                             accept;
   logic                             complete;
   logic                             timeout_fire;
   logic                             flush_req;
   logic                             flush_new;
   logic                             load_out;
   logic [RATIO-1:0][WIDTH_IN-1:0]   load_word;
   logic [LANES_W-1:0]               load_lanes;

   // The last lane bypasses the accumulator, so only completion needs a free output slot.
   assign slot_free = !out_valid_q | out_ready;
   assign in_ready  = !flush_pending_q & ((cnt_q != CNT_LAST) | slot_free);
   assign accept    = in_valid & in_ready;
   assign complete  = accept & (cnt_q == CNT_LAST);

   assign flush_req = flush | timeout_fire;
   assign flush_new = flush_req & !flush_pending_q & ((cnt_q != '0) | accept) & !complete;
   assign load_out  = complete | (flush_new & slot_free) | (flush_pending_q & slot_free);

   // Word presented to the output register: accumulator plus any same-cycle accepted word.
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
         if (gi < RATIO - 1) begin : g_acc_lane
            assign load_word[gi] = (accept && (cnt_q == CNT_W'(gi))) ? in_data : acc_q[gi];
         end else begin : g_last_lane
            assign load_word[gi] = complete ? in_data : '0;
         end
      end
   endgenerate

   assign load_lanes = LANES_W'(cnt_q) + LANES_W'(accept);

`ifdef GLIP_UPSCALE_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = idle_q;
      if (accept) begin
         idle_d = IDLE_W'(TIMEOUT);
      end else if (cnt_q == '0) begin
         idle_d = '0;
      end else if (idle_q != '0) begin
         idle_d = idle_q - IDLE_W'(1);
      end
   end

   assign timeout_fire = (idle_q == IDLE_W'(1)) & (cnt_q != '0) & !accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT > 0);
   assign timeout_fire       = 1'b0;
`endif

   always_comb begin
      cnt_d           = cnt_q;
      out_data_d      = out_data_q;
      out_lanes_d     = out_lanes_q;
      out_valid_d     = out_valid_q;
      flush_pending_d = flush_pending_q;

      if (load_out) begin
         out_data_d      = load_word;
         out_lanes_d     = load_lanes;
         out_valid_d     = 1'b1;
         cnt_d           = '0;
         flush_pending_d = 1'b0;
      end else begin
         if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (flush_new) begin
            flush_pending_d = 1'b1;
         end
      end
   end

   // Lanes are zeroed whenever the partial word leaves, keeping padding at zero.
   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < RATIO - 1; i++) begin
         if (load_out) begin
            acc_d[i] = '0;
         end else if (accept && (cnt_q == CNT_W'(i))) begin
            acc_d[i] = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q           <= '0;
         acc_q           <= '0;
         out_data_q      <= '0;
         out_lanes_q     <= '0;
         out_valid_q     <= 1'b0;
         flush_pending_q <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         acc_q           <= acc_d;
         out_data_q      <= out_data_d;
         out_lanes_q     <= out_lanes_d;
         out_valid_q     <= out_valid_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_lanes = out_lanes_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_glip_stream_upscale.sv
// Bench for glip_stream_upscale: RATIO=2 and RATIO=4 instances share stimulus; a lane-list
// scoreboard predicts every output word. Timeout checks run when GLIP_UPSCALE_TIMEOUT_EN is defined.
module tb_glip_stream_upscale;

   localparam int TO2 = 8;
   localparam int TO4 = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready2, out_valid2;
   logic [31:0] out_data2;
   logic [1:0]  out_lanes2;
   logic        in_ready4, out_valid4;
   logic [63:0] out_data4;
   logic [2:0]  out_lanes4;

   always #5 clk = ~clk;

   glip_stream_upscale #(.WIDTH_IN(16), .RATIO(2), .TIMEOUT(TO2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
      .flush(flush), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
      .out_lanes(out_lanes2));

   glip_stream_upscale #(.WIDTH_IN(16), .RATIO(4), .TIMEOUT(TO4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
      .flush(flush), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
      .out_lanes(out_lanes4));

   int nvec = 0;
   int nerr = 0;

   // Reference model: per instance, the list of lanes gathered so far and the expected word queue.
   logic [63:0] part_w [2];
   int          part_n [2];
   int          idle_c [2];
   logic [71:0] expq0 [$];
   logic [71:0] expq1 [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int k, input logic [71:0] e);
      if (k == 0) expq0.push_back(e);
      else        expq1.push_back(e);
   endtask

   task automatic emit_partial(input int k);
      push_exp(k, {8'(part_n[k]), part_w[k]});
      part_w[k] = '0;
      part_n[k] = 0;
   endtask

   task automatic model_dut(input int k, input int ratio, input int to, input bit acc,
                            input bit xfer, input logic [63:0] od, input logic [7:0] ol);
      logic [71:0] e;
      bit          have;
      bit          fl;
      if (xfer) begin
         have = (k == 0) ? (expq0.size() != 0) : (expq1.size() != 0);
         chk($sformatf("word_expected_r%0d", ratio), 64'(have), 64'd1);
         if (have) begin
            e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
            chk($sformatf("word_data_r%0d", ratio), od, e[63:0]);
            chk($sformatf("word_lanes_r%0d", ratio), 64'(ol), 64'(e[71:64]));
         end
      end
      fl = flush;
      if (acc) begin
         part_w[k][part_n[k]*16 +: 16] = in_data;
         part_n[k]++;
         idle_c[k] = 0;
         if (part_n[k] == ratio) emit_partial(k);
      end else begin
         idle_c[k]++;
`ifdef GLIP_UPSCALE_TIMEOUT_EN
         if (idle_c[k] == to) fl = 1'b1;
`else
         if (to < 0) fl = 1'b1;
`endif
      end
      if (fl && part_n[k] > 0) emit_partial(k);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         part_w[k] = '0;
         part_n[k] = 0;
         idle_c[k] = 0;
      end
      expq0.delete();
      expq1.delete();
   endtask

   // One clock cycle: inputs already driven just after a falling edge.
   task automatic step();
      bit a2, a4, x2, x4;
      #1;
      if (rst_n) begin
         a2 = in_valid & in_ready2;
         a4 = in_valid & in_ready4;
         x2 = out_valid2 & out_ready;
         x4 = out_valid4 & out_ready;
         model_dut(0, 2, TO2, a2, x2, {32'h0, out_data2}, {6'h0, out_lanes2});
         model_dut(1, 4, TO4, a4, x4, out_data4, {5'h0, out_lanes4});
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [15:0] d, input bit f, input bit r);
      in_valid  = v;
      in_data   = d;
      flush     = f;
      out_ready = r;
   endtask

   task automatic drain();
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      step();
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      repeat (4) step();
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid_r2", 64'(out_valid2), 64'd0);
      chk("rst_data_r2", 64'(out_data2), 64'd0);
      chk("rst_lanes_r2", 64'(out_lanes2), 64'd0);
      chk("rst_valid_r4", 64'(out_valid4), 64'd0);
      chk("rst_data_r4", out_data4, 64'd0);
      chk("rst_lanes_r4", 64'(out_lanes4), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready_r2", 64'(in_ready2), 64'd1);
      chk("rst_in_ready_r4", 64'(in_ready4), 64'd1);
      @(negedge clk);

      // Two words, free-running consumer.
      drive(1'b1, 16'h1111, 1'b0, 1'b1); step();
      chk("t1_latency", 64'(out_valid2), 64'd0);
      drive(1'b1, 16'h2222, 1'b0, 1'b1); step();
      chk("t1_valid", 64'(out_valid2), 64'd1);
      chk("t1_data", 64'(out_data2), 64'h2222_1111);
      chk("t1_lanes", 64'(out_lanes2), 64'd2);
      drive(1'b0, 16'h0, 1'b0, 1'b1); step();
      chk("t1_one_cycle", 64'(out_valid2), 64'd0);
      drain();

      // Stalled consumer: filling continues, completion blocks.
      drive(1'b1, 16'h00A0, 1'b0, 1'b0); step();
      drive(1'b1, 16'h00A1, 1'b0, 1'b0); step();
      chk("t2_first_word", 64'(out_data2), 64'h00A1_00A0);
      drive(1'b1, 16'h00A2, 1'b0, 1'b0); step();
      drive(1'b1, 16'h00A3, 1'b0, 1'b0); #1;
      chk("t2_stall", 64'(in_ready2), 64'd0);
      step();
      chk("t2_hold", 64'(out_data2), 64'h00A1_00A0);
      drive(1'b1, 16'h00A3, 1'b0, 1'b1); #1;
      chk("t2_resume", 64'(in_ready2), 64'd1);
      step();
      chk("t2_second_word", 64'(out_data2), 64'h00A3_00A2);
      chk("t2_second_valid", 64'(out_valid2), 64'd1);
      drive(1'b0, 16'h0, 1'b0, 1'b1); step();
      chk("t2_idle", 64'(out_valid2), 64'd0);
      drain();

      // Partial flush on the 4-lane instance.
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 16'(i), 1'b0, 1'b1); step();
      end
      drive(1'b0, 16'h0, 1'b1, 1'b1); step();
      chk("t3_valid", 64'(out_valid4), 64'd1);
      chk("t3_data", out_data4, 64'h0000_0003_0002_0001);
      chk("t3_lanes", 64'(out_lanes4), 64'd3);
      drive(1'b0, 16'h0, 1'b0, 1'b1); step();

      // Flush on an empty accumulator is a no-op.
      drive(1'b0, 16'h0, 1'b1, 1'b1); step();
      chk("t4_empty_flush_r2", 64'(out_valid2), 64'd0);
      chk("t4_empty_flush_r4", 64'(out_valid4), 64'd0);

      // Flush coincident with the completing word.
      for (int i = 5; i <= 7; i++) begin
         drive(1'b1, 16'(i), 1'b0, 1'b1); step();
      end
      drive(1'b1, 16'h0008, 1'b1, 1'b1); step();
      chk("t5_lanes", 64'(out_lanes4), 64'd4);
      chk("t5_data", out_data4, 64'h0008_0007_0006_0005);
      drive(1'b0, 16'h0, 1'b0, 1'b1); step();
      chk("t5_no_extra", 64'(out_valid4), 64'd0);
      drain();

      // Flush against a busy output slot.
      drive(1'b1, 16'h00C1, 1'b0, 1'b0); step();
      drive(1'b1, 16'h00C2, 1'b0, 1'b0); step();
      drive(1'b1, 16'h00C3, 1'b0, 1'b0); step();
      drive(1'b0, 16'h0, 1'b1, 1'b0); step();
      chk("t6_pending_block", 64'(in_ready2), 64'd0);
      drive(1'b0, 16'h0, 1'b0, 1'b0); step();
      chk("t6_pending_hold", 64'(in_ready2), 64'd0);
      chk("t6_pending_data", 64'(out_data2), 64'h00C2_00C1);
      drive(1'b0, 16'h0, 1'b0, 1'b1); step();
      chk("t6_partial_valid", 64'(out_valid2), 64'd1);
      chk("t6_partial_data", 64'(out_data2), 64'h0000_00C3);
      chk("t6_partial_lanes", 64'(out_lanes2), 64'd1);
      chk("t6_ready_back", 64'(in_ready2), 64'd1);
      drive(1'b0, 16'h0, 1'b0, 1'b1); step();
      drain();

`ifdef GLIP_UPSCALE_TIMEOUT_EN
      drive(1'b1, 16'hBEEF, 1'b0, 1'b1); step();
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      n = 0;
      while (!out_valid2 && n < 20) begin
         step();
         n++;
      end
      chk("to_delay", 64'(n), 64'd8);
      chk("to_data", 64'(out_data2), 64'h0000_BEEF);
      chk("to_lanes", 64'(out_lanes2), 64'd1);
      repeat (16) step();
`else
      n = 0;
`endif

      // Randomized traffic against the scoreboard.
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 6,
               $urandom_range(0, 99) < 60);
         step();
      end
      drive(1'b0, 16'h0, 1'b1, 1'b1); step();
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      repeat (10) step();
      chk("final_queue_r2", 64'(expq0.size()), 64'd0);
      chk("final_queue_r4", 64'(expq1.size()), 64'd0);
      chk("final_part_r2", 64'(part_n[0]), 64'd0);
      chk("final_part_r4", 64'(part_n[1]), 64'd0);

      // Reset in the middle of a fill discards everything.
      drive(1'b1, 16'h0D01, 1'b0, 1'b0); step();
      drive(1'b1, 16'h0D02, 1'b0, 1'b0); step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid_r2", 64'(out_valid2), 64'd0);
      chk("mid_rst_valid_r4", 64'(out_valid4), 64'd0);
      chk("mid_rst_data_r2", 64'(out_data2), 64'd0);
      model_reset();
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) step();
      chk("post_rst_quiet_r2", 64'(out_valid2), 64'd0);
      chk("post_rst_quiet_r4", 64'(out_valid4), 64'd0);
      chk("post_rst_queue", 64'(expq0.size() + expq1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
